// File: rtl/swizzle_pkg.sv
// Shared definitions for the CRAM<->DRAM swizzle blocks: default geometry,
// FSM state encoding and the memory-controller base address.
package swizzle_pkg;

   localparam int DWIDTH_DEF          = 40;
   localparam int AWIDTH_DEF          = 9;
   localparam int BLOCK_DEF           = 40;
   localparam int LOG_BLOCK_DEF       = 6;
   localparam int TOTAL_WORDS_DEF     = 480;
   localparam int MEM_CTRL_START_ADDR = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FILL   = 3'd1,
      ST_STREAM = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } swz_state_e;

endpackage

// File: rtl/swizzle_dram_to_cram_transpose_buffer.sv
// One BLOCK x DWIDTH bit matrix. Rows are written one per cycle while
// load_unload is high; the selected column is always presented on col_out.
module transpose_buffer
   import swizzle_pkg::*;
#(
   parameter int DWIDTH    = DWIDTH_DEF,
   parameter int BLOCK     = BLOCK_DEF,
   parameter int LOG_BLOCK = LOG_BLOCK_DEF
) (
   input  logic                 clk,
   input  logic                 load_unload,
   input  logic [LOG_BLOCK-1:0] row_sel,
   input  logic [LOG_BLOCK-1:0] col_sel,
   input  logic [DWIDTH-1:0]    data_in,
   output logic [DWIDTH-1:0]    col_out
);

   logic [DWIDTH-1:0] mat [BLOCK];

   // Row write; storage carries no reset, its contents only matter once loaded.
   always_ff @(posedge clk) begin
      if (load_unload) mat[row_sel] <= data_in;
   end

   // Column read: output bit i is bit col_sel of row i.
   always_comb begin
      col_out = '0;
      for (int i = 0; i < DWIDTH; i++) col_out[i] = mat[i][col_sel];
   end

endmodule

// File: rtl/swizzle_dram_to_cram.sv
// Streams row-major words from the memory controller, transposes each block
// of BLOCK words through a ping/pong pair of bit matrices and writes the
// column words into the CRAM port, back to back with no bubbles.
module swizzle_dram_to_cram
   import swizzle_pkg::*;
#(
   parameter int DWIDTH      = DWIDTH_DEF,
   parameter int AWIDTH      = AWIDTH_DEF,
   parameter int BLOCK       = BLOCK_DEF,
   parameter int LOG_BLOCK   = LOG_BLOCK_DEF,
   parameter int TOTAL_WORDS = TOTAL_WORDS_DEF
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   output logic              mem_ctrl_re,
   output logic [AWIDTH-1:0] mem_ctrl_addr,
   input  logic [DWIDTH-1:0] mem_ctrl_data_in,
   output logic              ram_we,
   output logic [AWIDTH-1:0] ram_addr,
   output logic [DWIDTH-1:0] ram_data_out,
   output logic              busy,
   output logic              done
);

   localparam logic [LOG_BLOCK-1:0] IDX_LAST     = LOG_BLOCK'(BLOCK - 1);
   localparam logic [AWIDTH-1:0]    ADDR_LAST    = AWIDTH'(TOTAL_WORDS - 1);
   localparam logic [AWIDTH-1:0]    ADDR_START   = AWIDTH'(MEM_CTRL_START_ADDR);
   localparam bit                   SINGLE_BLOCK = (TOTAL_WORDS == BLOCK);

   swz_state_e state, state_nxt;

   logic                 vld_p0;
   logic [AWIDTH-1:0]    rd_addr_p0;
   logic [LOG_BLOCK-1:0] rd_row_p0;
   logic                 rd_buf_p0;

   logic                 vld_p1;
   logic [LOG_BLOCK-1:0] row_p1;
   logic                 buf_p1;

   logic                 unl_run, unl_start, vld_p2;
   logic [LOG_BLOCK-1:0] col_p2;
   logic                 buf_p2;
   logic [AWIDTH-1:0]    wr_addr_p2;

   logic [DWIDTH-1:0]    col_ping, col_pong, col_word;

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= ST_IDLE;
      else         state <= state_nxt;
   end

   // FSM next state plus read enable, busy and done decode.
   always_comb begin
      state_nxt = state;
      vld_p0    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = ST_FILL;
         end
         ST_FILL: begin
            vld_p0 = 1'b1;
            if (rd_row_p0 == IDX_LAST) state_nxt = SINGLE_BLOCK ? ST_DRAIN : ST_STREAM;
         end
         ST_STREAM: begin
            vld_p0 = 1'b1;
            if (rd_addr_p0 == ADDR_LAST) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (ram_we && ram_addr == ADDR_LAST) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = ST_IDLE;
         end
      endcase
   end

   assign mem_ctrl_re   = vld_p0;
   assign mem_ctrl_addr = vld_p0 ? rd_addr_p0 : '0;

   // ---- p0: read issue; address, row-in-block and load-buffer select ----
   // Read counters advance every reading cycle and clear while idle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_addr_p0 <= ADDR_START;
         rd_row_p0  <= '0;
         rd_buf_p0  <= 1'b0;
      end else if (state == ST_IDLE) begin
         rd_addr_p0 <= ADDR_START;
         rd_row_p0  <= '0;
         rd_buf_p0  <= 1'b0;
      end else if (vld_p0) begin
         rd_addr_p0 <= rd_addr_p0 + AWIDTH'(1);
         if (rd_row_p0 == IDX_LAST) begin
            rd_row_p0 <= '0;
            rd_buf_p0 <= ~rd_buf_p0;
         end else begin
            rd_row_p0 <= rd_row_p0 + LOG_BLOCK'(1);
         end
      end
   end

   // ---- p1: read data returns; row/buffer steering delayed to match ----
   // Capture-side steering follows the read issue by one cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         vld_p1 <= 1'b0;
         row_p1 <= '0;
         buf_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         row_p1 <= rd_row_p0;
         buf_p1 <= rd_buf_p0;
      end
   end

   transpose_buffer #(.DWIDTH(DWIDTH), .BLOCK(BLOCK), .LOG_BLOCK(LOG_BLOCK)) u_ping (
      .clk         (clk),
      .load_unload (vld_p1 && !buf_p1),
      .row_sel     (row_p1),
      .col_sel     (col_p2),
      .data_in     (mem_ctrl_data_in),
      .col_out     (col_ping)
   );

   transpose_buffer #(.DWIDTH(DWIDTH), .BLOCK(BLOCK), .LOG_BLOCK(LOG_BLOCK)) u_pong (
      .clk         (clk),
      .load_unload (vld_p1 && buf_p1),
      .row_sel     (row_p1),
      .col_sel     (col_p2),
      .data_in     (mem_ctrl_data_in),
      .col_out     (col_pong)
   );

   // ---- p2: column unload, starts in the cycle the first block's last row lands ----
   assign unl_start = vld_p1 && (row_p1 == IDX_LAST) && !unl_run;
   assign vld_p2    = unl_run || unl_start;

   // Unload counters; once started they run continuously until the last column.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         unl_run    <= 1'b0;
         col_p2     <= '0;
         buf_p2     <= 1'b0;
         wr_addr_p2 <= '0;
      end else if (state == ST_IDLE) begin
         unl_run    <= 1'b0;
         col_p2     <= '0;
         buf_p2     <= 1'b0;
         wr_addr_p2 <= '0;
      end else if (vld_p2) begin
         unl_run    <= (wr_addr_p2 != ADDR_LAST);
         wr_addr_p2 <= wr_addr_p2 + AWIDTH'(1);
         if (col_p2 == IDX_LAST) begin
            col_p2 <= '0;
            buf_p2 <= ~buf_p2;
         end else begin
            col_p2 <= col_p2 + LOG_BLOCK'(1);
         end
      end
   end

   // Column 0 is read in the same cycle the block's last row is being
   // written, so that row's bit 0 is taken straight from the read data.
   always_comb begin
      col_word = buf_p2 ? col_pong : col_ping;
      if (col_p2 == '0) col_word[BLOCK-1] = mem_ctrl_data_in[0];
   end

   // ---- p3: registered CRAM write port; data forced to 0 when not writing ----
   // Output registers for the CRAM port.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ram_we       <= 1'b0;
         ram_addr     <= '0;
         ram_data_out <= '0;
      end else begin
         ram_we       <= vld_p2;
         ram_addr     <= vld_p2 ? wr_addr_p2 : '0;
         ram_data_out <= vld_p2 ? col_word : '0;
      end
   end

endmodule

// File: tb/tb_swizzle_dram_to_cram.sv
// Bench for swizzle_dram_to_cram: a 480-word instance and a 40-word instance,
// scoreboard of expected CRAM writes plus per-cycle control timing checks.
module tb_swizzle_dram_to_cram;

   localparam int DW  = 40;
   localparam int AW  = 9;
   localparam int B   = 40;
   localparam int TWA = 480;
   localparam int TWB = 40;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetn, start_a, start_b;
   logic re_a, we_a, busy_a, done_a, re_b, we_b, busy_b, done_b;
   logic [AW-1:0] maddr_a, raddr_a, maddr_b, raddr_b;
   logic [DW-1:0] mdata_a, rdata_a, mdata_b, rdata_b;

   logic [DW-1:0] img_a [TWA];
   logic [DW-1:0] img_b [TWB];
   exp_t q_a[$];
   exp_t q_b[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int act[2];
   int t0[2];
   int tot[2];

   swizzle_dram_to_cram dut_a (
      .clk(clk), .resetn(resetn), .start(start_a),
      .mem_ctrl_re(re_a), .mem_ctrl_addr(maddr_a), .mem_ctrl_data_in(mdata_a),
      .ram_we(we_a), .ram_addr(raddr_a), .ram_data_out(rdata_a),
      .busy(busy_a), .done(done_a)
   );

   swizzle_dram_to_cram #(.TOTAL_WORDS(TWB)) dut_b (
      .clk(clk), .resetn(resetn), .start(start_b),
      .mem_ctrl_re(re_b), .mem_ctrl_addr(maddr_b), .mem_ctrl_data_in(mdata_b),
      .ram_we(we_b), .ram_addr(raddr_b), .ram_data_out(rdata_b),
      .busy(busy_b), .done(done_b)
   );

   // DRAM model: data appears one cycle after the read-enable cycle; noise in reset.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!resetn) begin
         mdata_a <= DW'({$urandom, $urandom});
         mdata_b <= DW'({$urandom, $urandom});
      end else begin
         if (re_a) mdata_a <= img_a[maddr_a];
         if (re_b) mdata_b <= img_b[maddr_b];
      end
   end

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
      end
   endtask

   // Reference transpose: CRAM word m of block b = column j across rows b*B..b*B+B-1.
   function automatic logic [DW-1:0] model_word(input int id, input int m);
      logic [DW-1:0] w;
      int b, j;
      b = m / B;
      j = m % B;
      w = '0;
      for (int i = 0; i < B; i++) w[i] = (id == 0) ? img_a[b*B + i][j] : img_b[b*B + i][j];
      return w;
   endfunction

   task automatic arm(input int id);
      exp_t e;
      t0[id]  = cyc;
      tot[id] = (id == 0) ? TWA : TWB;
      for (int m = 0; m < tot[id]; m++) begin
         e.a = AW'(m);
         e.d = model_word(id, m);
         if (id == 0) q_a.push_back(e);
         else         q_b.push_back(e);
      end
      act[id] = 1;
   endtask

   task automatic go(input int id);
      @(negedge clk);
      if (id == 0) start_a = 1'b1;
      else         start_b = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      arm(id);
   endtask

   task automatic mon(input int id, input logic re, input logic [AW-1:0] ra,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic bsy, input logic dn);
      int rel, t, qs;
      exp_t e;
      string nm;
      if (act[id] == 0) return;
      rel = cyc - t0[id];
      t   = tot[id];
      nm  = (id == 0) ? "a" : "b";
      chk({nm, "_ctl_re_we_busy_done"}, 64'({re, we, bsy, dn}),
          64'({rel < t, (rel >= B + 1) && (rel <= t + B), rel <= t + B + 1, rel == t + B + 1}));
      if (re) chk({nm, "_mem_addr"}, 64'(ra), 64'(rel));
      if (we) begin
         qs = (id == 0) ? q_a.size() : q_b.size();
         if (qs == 0) begin
            total++;
            bad++;
            $display("FAIL %s_unexpected_write: addr %0d with nothing expected", nm, wa);
         end else begin
            if (id == 0) e = q_a.pop_front();
            else         e = q_b.pop_front();
            chk({nm, "_ram_addr"}, 64'(wa), 64'(e.a));
            chk({nm, "_ram_data"}, 64'(wd), 64'(e.d));
         end
      end
      if (rel == t + B + 2) begin
         qs = (id == 0) ? q_a.size() : q_b.size();
         chk({nm, "_writes_missing"}, 64'(qs), 64'(0));
         act[id] = 0;
      end
   endtask

   always @(negedge clk) begin
      mon(0, re_a, maddr_a, we_a, raddr_a, rdata_a, busy_a, done_a);
      mon(1, re_b, maddr_b, we_b, raddr_b, rdata_b, busy_b, done_b);
   end

   task automatic rst_chk(input int id);
      if (id == 0)
         chk("a_outputs_zero", 64'({re_a, maddr_a, we_a, raddr_a, rdata_a, busy_a, done_a}), 64'(0));
      else
         chk("b_outputs_zero", 64'({re_b, maddr_b, we_b, raddr_b, rdata_b, busy_b, done_b}), 64'(0));
   endtask

   task automatic wait_end(input int id);
      int n;
      n = 0;
      while (act[id] != 0 && n < 1500) begin
         @(negedge clk);
         n++;
      end
      if (act[id] != 0) begin
         total++;
         bad++;
         $display("FAIL timeout_%0d: transfer did not finish within %0d cycles", id, n);
         act[id] = 0;
      end
   endtask

   function automatic logic [DW-1:0] hash_word(input int w);
      logic [31:0] p;
      logic [8:0]  w9;
      w9 = w[8:0];
      p  = 32'(w) * 32'h9E37;
      return {w9, ~w9, p[21:0]};
   endfunction

   initial begin
      int n;
      act[0] = 0; act[1] = 0;
      t0[0] = 0; t0[1] = 0;
      tot[0] = TWA; tot[1] = TWB;
      resetn  = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;

      // Reset held with random inputs, then released without start.
      repeat (5) begin
         @(negedge clk);
         start_a = 1'($urandom);
         start_b = 1'($urandom);
         #1;
         rst_chk(0);
         rst_chk(1);
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      resetn  = 1'b1;
      repeat (4) begin
         @(negedge clk);
         #1;
         rst_chk(0);
         rst_chk(1);
      end

      // Single-block instance: one-hot rows transpose to one-hot columns.
      for (int i = 0; i < TWB; i++) img_b[i] = DW'(1) << i;
      go(1);
      wait_end(1);

      // Full transfer of the hash pattern, with a stray start at cycle 100.
      for (int w = 0; w < TWA; w++) img_a[w] = hash_word(w);
      go(0);
      while (cyc - t0[0] < 100) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      // After the reads finish, load the next image and hold start through DONE.
      while (cyc - t0[0] < 500) @(negedge clk);
      for (int w = 0; w < TWA; w++) img_a[w] = (w < B) ? '0 : DW'({$urandom, $urandom});
      img_a[5] = '1;
      start_a = 1'b1;
      n = 0;
      while (done_a !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("a_done_cycle", 64'(cyc - t0[0]), 64'(TWA + B + 1));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("a_restart_re_addr", 64'({re_a, maddr_a}), 64'({1'b1, 9'd0}));
      start_a = 1'b0;
      arm(0);
      wait_end(0);

      // Random data, reset dropped at cycle 200, then a clean full transfer.
      for (int w = 0; w < TWA; w++) img_a[w] = DW'({$urandom, $urandom});
      go(0);
      while (cyc - t0[0] < 200) begin
         @(posedge clk);
         #1;
      end
      chk("a_busy_before_reset", 64'({re_a, we_a, busy_a}), 64'(3'b111));
      #1;
      resetn = 1'b0;
      act[0] = 0;
      q_a.delete();
      #1;
      rst_chk(0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      for (int w = 0; w < TWA; w++) img_a[w] = DW'({$urandom, $urandom});
      go(0);
      wait_end(0);

      // Random data through the single-block instance.
      for (int i = 0; i < TWB; i++) img_b[i] = DW'({$urandom, $urandom});
      go(1);
      wait_end(1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
